// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the key debounce/encoder slice.
//   deb_state_t : per-key debounce state (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT)
//   KEY_UP/KEY_DN : bit index of each button in Key_In / Key_Press
//   MODE_W      : width of the mode value driven on Key_Out
//   step_mode() : next mode value for a pair of (already gated) key events
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int KEY_UP   = 0;
  localparam int KEY_DN   = 1;
  localparam int NUM_KEYS = 2;
  localparam int MODE_W   = 2;

  // UP alone steps +1, DOWN alone steps -1, both or neither hold.
  // Arithmetic is MODE_W bits wide, so 3->0 and 0->3 wrap naturally.
  function automatic logic [MODE_W-1:0] step_mode(input logic [MODE_W-1:0] mode,
                                                  input logic [NUM_KEYS-1:0] ev);
    logic [MODE_W-1:0] result;
    result = mode;
    if (ev[KEY_UP] && !ev[KEY_DN])
      result = mode + MODE_W'(1);
    else if (ev[KEY_DN] && !ev[KEY_UP])
      result = mode - MODE_W'(1);
    return result;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one raw active-low button -> one-cycle press event.
//   Holds a 2-FF synchroniser, the 4-state debounce FSM with its stable-sample
//   counter and, when KEY_AUTOREPEAT_EN is defined, the auto-repeat counter.
// Ports:
//   clk         in  system clock
//   srst_n      in  synchronous active-low reset
//   key_raw     in  raw button level, active-low, asynchronous
//   event_pulse out combinational; high in the cycle whose clock edge confirms a
//                   press (or auto-repeat), so a register fed from it changes on
//                   the same edge the FSM enters PRESSED
// Configuration macro: KEY_AUTOREPEAT_EN
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic srst_n,
  input  logic key_raw,
  output logic event_pulse
);

  // Parameter sanity: counter must be able to hold DEBOUNCE_CYCLES, and the
  // repeat spacing must be at least one cycle.
  if (DEBOUNCE_CYCLES < 2 || (1 << CNT_W) <= DEBOUNCE_CYCLES ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_debounce: inconsistent DEBOUNCE/REPEAT parameters");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             key_sync;
  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             press_ev;
  logic             rep_fire;

  // Synchroniser idles at 1 (button released).
  always_ff @(posedge clk) begin
    if (!srst_n) sync_reg <= 2'b11;
    else         sync_reg <= {sync_reg[0], key_raw};
  end
  assign key_sync = sync_reg[1];

  // State register
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic. cnt holds the number of consecutive stable samples seen
  // so far; the sample that would make it DEBOUNCE_CYCLES moves the state on.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!key_sync) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (key_sync) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!key_sync) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    press_ev    = (state_reg == PRESS_WAIT) && !key_sync && (cnt_reg == CNT_LAST);
    event_pulse = press_ev | rep_fire;
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             rep_armed_reg, rep_armed_next;  // first repeat already fired
  logic [REP_W-1:0] rep_limit;
  logic             rep_hold;

  // Counter starts at 0 on the edge that enters PRESSED, so the value k is seen
  // k cycles after the initial event and fires on reaching limit-1.
  always_comb begin
    rep_hold       = (state_reg == PRESSED) && !key_sync;
    rep_limit      = rep_armed_reg ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
    rep_fire       = rep_hold && (rep_cnt_reg == rep_limit);
    rep_cnt_next   = '0;
    rep_armed_next = 1'b0;
    if (rep_hold) begin
      rep_armed_next = rep_armed_reg | rep_fire;
      rep_cnt_next   = rep_fire ? '0 : rep_cnt_reg + REP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rep_cnt_reg   <= '0;
      rep_armed_reg <= 1'b0;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_armed_reg <= rep_armed_next;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_encoder.sv
// key_debounce_encoder: debounces the UP/DOWN buttons and maintains the 2-bit
// mode value consumed by LED_Nixietube.
// Ports:
//   Sys_CLK   in   system clock
//   Sys_RST   in   synchronous active-low reset
//   EN        in   1 = events are accepted; 0 = events are dropped (FSMs keep running)
//   Key_In    in   [1:0] raw active-low buttons, [0]=UP, [1]=DOWN
//   Key_Out   out  [1:0] mode value
//   Key_Press out  [1:0] one-cycle strobe per accepted event of each key
//   Key_Valid out  one-cycle strobe on the cycle Key_Out has changed
// Configuration macro: KEY_AUTOREPEAT_EN (auto-repeat while a key is held)
module key_debounce_encoder
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic              EN,
  input  logic [1:0]        Key_In,
  output logic [MODE_W-1:0] Key_Out,
  output logic [1:0]        Key_Press,
  output logic              Key_Valid
);

  logic [NUM_KEYS-1:0] key_ev;
  logic [NUM_KEYS-1:0] ev_gated;
  logic [MODE_W-1:0]   mode_reg, mode_next;
  logic [NUM_KEYS-1:0] press_reg;
  logic                valid_reg;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_deb (
      .clk         (Sys_CLK),
      .srst_n      (Sys_RST),
      .key_raw     (Key_In[gi]),
      .event_pulse (key_ev[gi])
    );
  end

  // Events arriving while EN is low are dropped, not deferred.
  always_comb begin
    ev_gated  = key_ev & {NUM_KEYS{EN}};
    mode_next = step_mode(mode_reg, ev_gated);
  end

  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      mode_reg  <= '0;
      press_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      mode_reg  <= mode_next;
      press_reg <= ev_gated;
      valid_reg <= (mode_next != mode_reg);
    end
  end

  assign Key_Out   = mode_reg;
  assign Key_Press = press_reg;
  assign Key_Valid = valid_reg;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Testbench for key_debounce_encoder (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8). Stimulus pushes expected events into a queue; a monitor
// pops one entry whenever the DUT shows Key_Press or Key_Valid and compares
// strobe bits, mode value and arrival cycle.
// With DEBOUNCE_CYCLES=4 a key dropped just after edge t confirms on edge t+6.
module tb_key_debounce_encoder;

  logic       Sys_CLK = 1'b0;
  logic       Sys_RST = 1'b0;
  logic       EN      = 1'b1;
  logic [1:0] Key_In  = 2'b00;
  logic [1:0] Key_Out;
  logic [1:0] Key_Press;
  logic       Key_Valid;

  key_debounce_encoder #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .Sys_CLK   (Sys_CLK),
    .Sys_RST   (Sys_RST),
    .EN        (EN),
    .Key_In    (Key_In),
    .Key_Out   (Key_Out),
    .Key_Press (Key_Press),
    .Key_Valid (Key_Valid)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  typedef struct {
    logic [1:0] press;
    logic [1:0] mode;
    logic       valid;
    int         at;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   rst_at_edge = 1'b0;

  always @(posedge Sys_CLK) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !Sys_RST;
  end

  // Monitor / scoreboard
  always @(negedge Sys_CLK) begin
    if (rst_at_edge) begin
      vectors++;
      if (Key_Out !== 2'd0 || Key_Press !== 2'b00 || Key_Valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got out=%0d press=%b valid=%b, required out=0 press=00 valid=0",
                 cyc, Key_Out, Key_Press, Key_Valid);
      end
    end else if (Key_Press !== 2'b00 || Key_Valid !== 1'b0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got press=%b out=%0d valid=%b, required no event",
                 cyc, Key_Press, Key_Out, Key_Valid);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (Key_Press !== e.press || Key_Out !== e.mode || Key_Valid !== e.valid || cyc != e.at) begin
          miscompares++;
          $display("FAIL event_%0d got cyc=%0d press=%b out=%0d valid=%b, required cyc=%0d press=%b out=%0d valid=%b",
                   e.tag, cyc, Key_Press, Key_Out, Key_Valid, e.at, e.press, e.mode, e.valid);
        end else begin
          $display("event_%0d ok cyc=%0d press=%b out=%0d valid=%b", e.tag, cyc, Key_Press, Key_Out, Key_Valid);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Sys_CLK);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] p, input logic [1:0] m, input logic v,
                           input int at, input int tag);
    exp_t e;
    e.press = p;
    e.mode  = m;
    e.valid = v;
    e.at    = at;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  // Press key k for 'hold' cycles, then release and let it debounce.
  task automatic tap(input int k, input int hold);
    Key_In[k] = 1'b0;
    tick(hold);
    Key_In[k] = 1'b1;
    tick(8);
  endtask

  task automatic check_out(input logic [1:0] exp_mode, input string name);
    vectors++;
    if (Key_Out !== exp_mode) begin
      miscompares++;
      $display("FAIL %s got out=%0d, required out=%0d", name, Key_Out, exp_mode);
    end else begin
      $display("%s ok out=%0d", name, Key_Out);
    end
  endtask

  logic [1:0] wrap_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
`ifdef KEY_AUTOREPEAT_EN
  int         rep_off  [6] = '{0, 20, 28, 36, 44, 52};
  logic [1:0] rep_mode [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
`endif

  initial begin
    // 1: reset with both keys held low
    Sys_RST = 1'b0;
    Key_In  = 2'b00;
    EN      = 1'b1;
    tick(3);
    Key_In  = 2'b11;
    Sys_RST = 1'b1;
    tick(3);

    // 2: clean UP press, 0 -> 1
    expect_ev(2'b01, 2'd1, 1'b1, cyc + 6, 2);
    tap(0, 10);

    // 3: bounce never reaches four stable samples
    for (int i = 0; i < 2; i++) begin
      Key_In[0] = 1'b0;
      tick(2);
      Key_In[0] = 1'b1;
      tick(2);
    end
    tick(10);
    check_out(2'd1, "bounce_hold");

    // back to 0 with one DOWN press
    expect_ev(2'b10, 2'd0, 1'b1, cyc + 6, 3);
    tap(1, 10);

    // 4: wrap upward 1,2,3,0 then DOWN 0 -> 3
    for (int i = 0; i < 4; i++) begin
      expect_ev(2'b01, wrap_seq[i], 1'b1, cyc + 6, 40 + i);
      tap(0, 10);
    end
    expect_ev(2'b10, 2'd3, 1'b1, cyc + 6, 44);
    tap(1, 10);

    // 5: simultaneous press, mode holds at 3, no Key_Valid
    expect_ev(2'b11, 2'd3, 1'b0, cyc + 6, 5);
    Key_In = 2'b00;
    tick(10);
    Key_In = 2'b11;
    tick(8);

    // 6: EN low drops the event
    EN = 1'b0;
    tap(0, 10);
    check_out(2'd3, "en_low_hold");
    EN = 1'b1;
    tick(1);
    expect_ev(2'b01, 2'd0, 1'b1, cyc + 6, 60);
    tap(0, 10);
    expect_ev(2'b01, 2'd1, 1'b1, cyc + 6, 61);
    tap(0, 10);

    // reset while in PRESS_WAIT: press abandoned, mode cleared
    Key_In[0] = 1'b0;
    tick(3);
    Sys_RST   = 1'b0;
    Key_In[0] = 1'b1;
    tick(2);
    Sys_RST   = 1'b1;
    tick(10);
    check_out(2'd0, "reset_mid_press");

`ifdef KEY_AUTOREPEAT_EN
    // hold UP for 60 cycles: initial event plus five repeats
    begin
      int t0;
      t0 = cyc + 6;
      for (int i = 0; i < 6; i++)
        expect_ev(2'b01, rep_mode[i], 1'b1, t0 + rep_off[i], 70 + i);
      Key_In[0] = 1'b0;
      tick(60);
      Key_In[0] = 1'b1;
      tick(10);
    end
`endif

    tick(5);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event_%0d got no event, required press=%b out=%0d at cyc=%0d",
               e.tag, e.press, e.mode, e.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
